// File: rtl/exec_muldiv_seq.sv
// Radix-2 iterative RV32M multiply/divide sequencer beside the execute ALU.
// One shared 64-bit shift register and one 33-bit adder, one bit per cycle.
module exec_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1dat,
  input  logic [XLEN-1:0] rs2dat,
  input  logic [5:0]      rd,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [5:0]      rd_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [5:0]          rd_q, rd_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic [XLEN-1:0]     addend_q, addend_d;
  logic [2*XLEN-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                in_div;
  logic                sgn_a;
  logic                sgn_b;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic                div_zero;
  logic                div_ovf;
  logic [XLEN-1:0]     special_res;

  logic                is_mul_q;
  logic [XLEN:0]       add_a;
  logic [XLEN:0]       add_b;
  logic [XLEN:0]       sum;
  logic                q_bit;
  logic [2*XLEN-1:0]   sr_step;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix;
  logic [XLEN-1:0]     rem_fix;
  logic [XLEN-1:0]     fin_res;

  // Operand decode at accept time
  always_comb begin
    in_div = op[2];
    sgn_a  = rs1dat[XLEN-1] &
             ((op == OP_MULH) | (op == OP_MULHSU) |
              (op == OP_DIV)  | (op == OP_REM));
    sgn_b  = rs2dat[XLEN-1] &
             ((op == OP_MULH) | (op == OP_DIV) |
              (op == OP_REM));
    mag_a  = sgn_a ? (~rs1dat + 1'b1) : rs1dat;
    mag_b  = sgn_b ? (~rs2dat + 1'b1) : rs2dat;
    div_zero = (rs2dat == '0);
    div_ovf  = ((op == OP_DIV) | (op == OP_REM)) &
               (rs1dat == {1'b1, {(XLEN-1){1'b0}}}) &
               (rs2dat == '1);
    if (op[1]) begin
      special_res = div_zero ? rs1dat : '0;
    end else begin
      special_res = div_zero ? '1 :
                    {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // Shared adder: add for multiply, trial-subtract for divide
  always_comb begin
    is_mul_q = ~op_q[2];
    add_b    = {1'b0, addend_q};
    if (is_mul_q) begin
      add_a = {1'b0, sr_q[2*XLEN-1:XLEN]};
      sum   = add_a + add_b;
    end else begin
      add_a = {1'b0, sr_q[2*XLEN-2:XLEN-1]};
      sum   = add_a - add_b;
    end
  end

  // One iteration of the shift register
  always_comb begin
    q_bit = sr_q[2*XLEN-1] | ~sum[XLEN];
    if (is_mul_q) begin
      if (sr_q[0]) begin
        sr_step = {sum, sr_q[XLEN-1:1]};
      end else begin
        sr_step = {1'b0, sr_q[2*XLEN-1:1]};
      end
    end else begin
      sr_step = {q_bit ? sum[XLEN-1:0] :
                         sr_q[2*XLEN-2:XLEN-1],
                 sr_q[XLEN-2:0], q_bit};
    end
  end

  // Sign fix-up and result selection for the final iteration
  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? (~sr_step + 1'b1) : sr_step;
    quo_fix  = (sa_q ^ sb_q) ?
               (~sr_step[XLEN-1:0] + 1'b1) : sr_step[XLEN-1:0];
    rem_fix  = sa_q ?
               (~sr_step[2*XLEN-1:XLEN] + 1'b1) :
               sr_step[2*XLEN-1:XLEN];
    fin_res  = '0;
    unique case (op_q)
      3'd0:                fin_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fin_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fin_res = quo_fix;
      default:             fin_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    addend_d = addend_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d  = op;
          rd_d  = rd;
          sa_d  = sgn_a;
          sb_d  = sgn_b;
          cnt_d = '0;
          if (in_div) begin
            sr_d     = {{XLEN{1'b0}}, mag_a};
            addend_d = mag_b;
          end else begin
            sr_d     = {{XLEN{1'b0}}, mag_b};
            addend_d = mag_a;
          end
          if (in_div && (div_zero || div_ovf)) begin
            state_d  = S_FIN;
            result_d = special_res;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          sr_d  = sr_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d  = S_FIN;
            result_d = fin_res;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      addend_q <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      addend_q <= addend_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign stall  = (start && (state_q == S_IDLE)) ||
                  (state_q == S_CALC);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_exec_muldiv_seq.sv
// Bench for exec_muldiv_seq: table vectors, random ops vs
// an arithmetic model, flush/reset/back-to-back sequences.
module tb_exec_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1dat;
  logic [31:0] rs2dat;
  logic [5:0]  rd;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [5:0]  rd_out;

  int errors = 0;
  int checks = 0;

  exec_muldiv_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1dat (rs1dat),
    .rs2dat (rs2dat),
    .rd     (rd),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Plain arithmetic reference for RV32M semantics
  function automatic logic [31:0] model(input logic [2:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint pa;
    longint pb;
    longint unsigned pu;
    int sa;
    int sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model = '0;
    case (o)
      3'd0: model = a * b;
      3'd1: begin
        pa = longint'(sa);
        pb = longint'(sb);
        pa = pa * pb;
        model = pa[63:32];
      end
      3'd2: begin
        pa = longint'(sa);
        pb = longint'({32'h0, b});
        pa = pa * pb;
        model = pa[63:32];
      end
      3'd3: begin
        pu = {32'h0, a} * {32'h0, b};
        model = pu[63:32];
      end
      3'd4: begin
        if (b == 0) model = 32'hFFFF_FFFF;
        else if (ovf) model = 32'h8000_0000;
        else model = sa / sb;
      end
      3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) model = a;
        else if (ovf) model = '0;
        else model = sa % sb;
      end
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    logic sdiv;
    sdiv = (o == 3'd4) || (o == 3'd6);
    if (o[2] && (b == 0)) return 1;
    if (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  // Called just after a negedge with the DUT in IDLE
  task automatic run_op(input string nm, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] r, input logic [31:0] exp,
                        input int lat);
    int n;
    int st;
    st = 0;
    start = 1'b1; op = o; rs1dat = a; rs2dat = b; rd = r;
    #1;
    if (stall) st++;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    op     = 3'($urandom);
    rs1dat = $urandom;
    rs2dat = $urandom;
    rd     = 6'($urandom);
    n = 1;
    forever begin
      #1;
      if (done || n >= 40) break;
      if (stall) st++;
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, lat);
    chk({nm, " result"}, result, exp);
    chk({nm, " rd_out"}, 32'(rd_out), 32'(r));
    chk({nm, " stall_fin"}, 32'(stall), 32'd0);
    chk({nm, " stall_cycles"}, st, (lat == 1) ? 1 : 33);
    @(negedge clk);
    #1;
    chk({nm, " done_drop"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic quiet_window(input string nm);
    int seen;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk({nm, " no_done"}, seen, 0);
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    int n;

    tbl[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 6'd5, 32'hFFFF_FFEB, 33};
    tbl[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd6, 32'hFFFF_FFFE, 33};
    tbl[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd7, 32'h0, 33};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2, 6'd8, 32'hFFFF_FFFF, 33};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 6'd9, 32'hFFFF_FFFD, 33};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 6'd10, 32'hFFFF_FFFF, 33};
    tbl[6]  = '{3'd5, 32'd100, 32'd7, 6'd11, 32'd14, 33};
    tbl[7]  = '{3'd7, 32'd100, 32'd7, 6'd12, 32'd2, 33};
    tbl[8]  = '{3'd5, 32'h1234, 32'd0, 6'd13, 32'hFFFF_FFFF, 1};
    tbl[9]  = '{3'd6, 32'h1234, 32'd0, 6'd14, 32'h1234, 1};
    tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15,
                32'h8000_0000, 1};
    tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 6'd16, 32'h0, 1};
    tbl[12] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 6'd17, 32'h0, 33};
    tbl[13] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 6'd63,
                32'h4000_0000, 33};

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op = '0; rs1dat = '0; rs2dat = '0; rd = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", 32'(rd_out), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].rd, tbl[i].exp, tbl[i].lat);
    end

    for (int i = 0; i < 50; i++) begin
      o = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), o, a, b, 6'($urandom),
             model(o, a, b), exp_lat(o, a, b));
    end

    // Flush in the middle of CALC, then immediate new op
    start = 1'b1; op = 3'd0; rs1dat = 32'd5; rs2dat = 32'd6; rd = 6'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    run_op("post_flush", 3'd0, 32'd3, 32'd4, 6'd21, 32'd12, 33);

    // Flush together with start in IDLE drops the start
    start = 1'b1; flush = 1'b1; op = 3'd3;
    rs1dat = 32'd9; rs2dat = 32'd9; rd = 6'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_start busy", 32'(busy), 32'd0);
    quiet_window("flush_start");

    // Reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs1dat = 32'd1000; rs2dat = 32'd3;
    rd = 6'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst rd_out", 32'(rd_out), 32'd0);
    quiet_window("midrst");

    // Back-to-back: start held high, inputs swapped while busy
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1dat = 32'd11; rs2dat = 32'd13;
    rd = 6'd30;
    @(posedge clk);
    @(negedge clk);
    op = 3'd7; rs1dat = 32'd50; rs2dat = 32'd8; rd = 6'd31;
    n = 1;
    forever begin
      #1;
      if (done || n >= 40) break;
      @(negedge clk);
      n++;
    end
    chk("b2b first latency", n, 33);
    chk("b2b first result", result, 32'd143);
    chk("b2b first rd", 32'(rd_out), 32'd30);
    chk("b2b fin stall", 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    chk("b2b idle state", {30'd0, busy, done}, 32'd0);
    chk("b2b idle stall", 32'(stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    forever begin
      #1;
      if (done || n >= 40) break;
      @(negedge clk);
      n++;
    end
    chk("b2b second latency", n, 33);
    chk("b2b second result", result, 32'd2);
    chk("b2b second rd", 32'(rd_out), 32'd31);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_muldiv_seq.md
Name: exec_muldiv_seq

Overview:
- Iterative sequencer for the RV32M multiply/divide ops, sitting beside the execute-stage ALU.
- Accepts one op from decode/execute and holds the execute stage via `stall` while it iterates.
- Returns a 32-bit result plus the destination register number for writeback forwarding.
- Uses one shared 64-bit shift register and a 33-bit adder/subtractor, radix-2, one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold values 0..XLEN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new op; honoured only in IDLE.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1dat  in  32  operand A (multiplicand/dividend).
- rs2dat  in  32  operand B (multiplier/divisor).
- rd  in  6  destination register number, carried through.
- flush  in  1  abort the in-flight op (branch taken / pipeline flush).
- busy  out  1  registered; high in CALC and FIN.
- stall  out  1  combinational; equals (start and state==IDLE) or state==CALC.
- done  out  1  registered; one-cycle pulse, result valid.
- result  out  32  valid only while done=1.
- rd_out  out  6  latched rd; valid while done=1.

Behaviour:
- States:
  - IDLE: waiting for `start`.
  - CALC: iterating.
  - FIN: 1 cycle; done=1 and result is presented.
- Reset: state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0, internal registers=0. Reset wins over start and flush on the same edge.
- IDLE + start:
  - Latch op and rd.
  - Capture the operand signs:
    - DIV, REM, MULH: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - All other ops: both operands unsigned.
  - Load the operand magnitudes (two's-complement absolute value of each signed operand).
  - Clear the counter and go to CALC.
- Special divide cases (decided at start; no CALC cycles, go straight to FIN):
  - Divisor == 0: quotient = 0xFFFFFFFF, remainder = rs1dat.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Latency in this case: done is high in the cycle after start is sampled.
- CALC multiply:
  - Each edge: if the product LSB is 1, add the multiplicand to the upper half (33-bit add).
  - Then shift the 64-bit product register right by 1.
- CALC divide (restoring):
  - Each edge: shift {remainder, quotient} left by 1.
  - Trial-subtract the divisor from the remainder; if the result is non-negative, keep it and set the quotient LSB.
- CALC termination: counter increments each CALC edge; on the edge where counter==XLEN-1, go to FIN.
- Latency: exactly 32 CALC cycles. done is high in the 33rd cycle after the start-sample cycle.
- FIN sign fix-up, computed on the transition into FIN:
  - Product: negate the 64-bit product if sign(A) xor sign(B).
  - Quotient: negate if sign(A) xor sign(B).
  - Remainder: negate if sign(A).
- FIN result selection:
  - MUL: low 32 bits of the product.
  - MULH, MULHSU, MULHU: high 32 bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- FIN exit: next edge goes to IDLE and done drops.
  - A start in FIN is ignored.
  - The earliest next accept is the cycle after FIN.
- Back-to-back: a start held high across FIN is accepted in the following IDLE cycle.
- flush:
  - In CALC or FIN: next state IDLE, done=0 on the next cycle; no result is produced.
  - Same cycle as a start in IDLE: the start is dropped and the state stays IDLE.
  - Flush has priority over the CALC→FIN transition.
- Stability: start, op, and operand changes while busy=1 have no effect; operands are sampled only at accept.
- stall: low in FIN so the pipeline advances with the result in that cycle.

Test Plan:
- Reset then MUL rs1=7, rs2=0xFFFFFFFD → stall high for 33 cycles, done pulses once in cycle 33 with result=0xFFFFFFEB and rd_out=the rd sampled at start.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result 0xFFFFFFFE; MULH with the same operands → 0x00000000; MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 0x1234/0 → done the cycle after start, result 0xFFFFFFFF; REM 0x1234/0 → 0x1234; DIV 0x80000000/0xFFFFFFFF → 0x80000000, also 1-cycle latency.
- Flush at CALC cycle 10 → busy drops next cycle, no done pulse; a new MUL 3×4 accepted immediately after → result 12 at cycle 33.
- Reset asserted at CALC cycle 20 → all outputs 0 next cycle, done never pulses; start held high through the FIN cycle → second op accepted the cycle after FIN.
